// File: rtl/aes_pkg.sv
// Shared AES output-path definitions: block/word widths, words-per-block helper and
// the serializer state type.
package aes_pkg;

  localparam int unsigned AES_BLK_W  = 128;
  localparam int unsigned AES_WORD_W = 32;

  function automatic int unsigned calc_wpb(input int unsigned data_w, input int unsigned out_w);
    return data_w / out_w;
  endfunction

  typedef enum logic {
    IDLE,
    SEND
  } out_state_t;

endpackage

// File: rtl/aes_blk_fifo.sv
// Register-array block FIFO with level and full/empty flags. The caller guarantees a push at
// full only together with a pop.
module aes_blk_fifo #(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] level_q;

  // Storage needs no reset; the head is only observed while the level is non-zero.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign level = level_q;
  assign full  = (level_q == LVL_W'(DEPTH));
  assign empty = (level_q == '0);

endmodule

// File: rtl/aes_out_serializer.sv
// Buffers AES ciphertext blocks and streams them MS word first over valid/ready.
// Optional macro AES_OUT_DROP_CNT_EN adds a saturating 16-bit drop_count output.
module aes_out_serializer
  import aes_pkg::*;
#(
  parameter int unsigned DATA_W     = AES_BLK_W,
  parameter int unsigned OUT_W      = AES_WORD_W,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  input  logic [DATA_W-1:0]             in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [OUT_W-1:0]              out_data,
  output logic                          out_last,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
`ifdef AES_OUT_DROP_CNT_EN
  ,
  output logic [15:0]                   drop_count
`endif
);

  localparam int unsigned WPB   = calc_wpb(DATA_W, OUT_W);
  localparam int unsigned IDX_W = (WPB > 1) ? $clog2(WPB) : 1;
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WPB - 1);

  out_state_t        state_q, state_d;
  logic [IDX_W-1:0]  word_idx_q, word_idx_d;
  logic [DATA_W-1:0] head;
  logic              full, empty;
  logic              xfer, pop, push, drop;
  logic              overflow_q;

  assign out_valid = (state_q == SEND);
  assign out_last  = out_valid && (word_idx_q == LAST_IDX);
  assign xfer      = out_valid && out_ready;
  assign pop       = xfer && out_last && !empty;
  // A full FIFO still accepts a block when its head leaves in the same cycle.
  assign push      = in_valid && (!full || pop);
  assign drop      = in_valid && full && !pop;

  aes_blk_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (in_data),
    .rdata (head),
    .level (fifo_level),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    out_data = '0;
    for (int k = 0; k < int'(WPB); k++) begin
      if (out_valid && (word_idx_q == IDX_W'(k))) begin
        out_data = head[DATA_W-1-k*OUT_W -: OUT_W];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    word_idx_d = word_idx_q;
    if (xfer) begin
      word_idx_d = out_last ? '0 : word_idx_q + IDX_W'(1);
    end
    case (state_q)
      IDLE: begin
        if (push) state_d = SEND;
      end
      SEND: begin
        if (pop && !push && (fifo_level == LVL_W'(1))) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      word_idx_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_idx_q <= word_idx_d;
      if (drop) overflow_q <= 1'b1;
    end
  end

  assign overflow = overflow_q;

`ifdef AES_OUT_DROP_CNT_EN
  logic [15:0] drop_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_cnt_q <= '0;
    end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_aes_out_serializer.sv
// Directed and random checks of aes_out_serializer against a block-queue reference model.
module tb_aes_out_serializer;

  localparam int DEPTH = 4;
  localparam int WPB   = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_data;
  logic         out_last;
  logic [2:0]   fifo_level;
  logic         overflow;
`ifdef AES_OUT_DROP_CNT_EN
  logic [15:0]  drop_count;
`endif

  aes_out_serializer dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .fifo_level (fifo_level),
    .overflow   (overflow)
`ifdef AES_OUT_DROP_CNT_EN
    ,
    .drop_count (drop_count)
`endif
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: queued blocks, index of next word of the head, sticky flags.
  logic [127:0] mq[$];
  int           widx;
  logic         m_ovf;
  int           m_drops;
  int           max_level;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    mq.delete();
    widx    = 0;
    m_ovf   = 1'b0;
    m_drops = 0;
  endtask

  task automatic check_outputs();
    logic         ev;
    logic [127:0] sh;
    logic [31:0]  ed;
    ev = (mq.size() != 0);
    ed = '0;
    if (ev) begin
      sh = mq[0] >> ((WPB - 1 - widx) * 32);
      ed = sh[31:0];
    end
    chk("out_valid", 128'(out_valid), 128'(ev));
    chk("out_data", 128'(out_data), 128'(ed));
    chk("out_last", 128'(out_last), 128'(ev && widx == WPB - 1));
    chk("fifo_level", 128'(fifo_level), 128'(mq.size()));
    chk("overflow", 128'(overflow), 128'(m_ovf));
`ifdef AES_OUT_DROP_CNT_EN
    chk("drop_count", 128'(drop_count), 128'(m_drops));
`endif
  endtask

  task automatic model_edge(input logic v, input logic [127:0] d, input logic r);
    logic xfer;
    xfer = (mq.size() != 0) && r;
    if (xfer) begin
      if (widx == WPB - 1) begin
        widx = 0;
        void'(mq.pop_front());
      end else begin
        widx++;
      end
    end
    if (v) begin
      if (mq.size() < DEPTH) mq.push_back(d);
      else begin
        m_ovf = 1'b1;
        if (m_drops < 65535) m_drops++;
      end
    end
    if (mq.size() > max_level) max_level = mq.size();
  endtask

  task automatic step(input logic v, input logic [127:0] d, input logic r);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_edge(v, d, r);
    #1;
  endtask

  function automatic logic [127:0] rnd_blk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    model_reset();
    max_level = 0;
    #1;
    chk("reset out_valid", 128'(out_valid), 128'(0));
    chk("reset out_data", 128'(out_data), 128'(0));
    chk("reset out_last", 128'(out_last), 128'(0));
    chk("reset fifo_level", 128'(fifo_level), 128'(0));
    chk("reset overflow", 128'(overflow), 128'(0));
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Single known block, sink always ready.
    step(1'b1, 128'h00112233_44556677_8899AABB_CCDDEEFF, 1'b1);
    repeat (6) step(1'b0, '0, 1'b1);

    // Backpressure: stall five cycles, then alternate ready.
    step(1'b1, rnd_blk(), 1'b0);
    repeat (5) step(1'b0, '0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, '0, (i % 2) == 0);
    repeat (2) step(1'b0, '0, 1'b1);

    // Full FIFO with simultaneous push and last-word pop.
    repeat (4) step(1'b1, rnd_blk(), 1'b0);
    repeat (3) step(1'b0, '0, 1'b1);
    step(1'b1, rnd_blk(), 1'b1);
    chk("full push/pop level", 128'(fifo_level), 128'(4));
    chk("full push/pop overflow", 128'(overflow), 128'(0));
    repeat (18) step(1'b0, '0, 1'b1);

    // Overflow: five pushes into a stalled FIFO drop the fifth.
    repeat (5) step(1'b1, rnd_blk(), 1'b0);
    chk("ovf level", 128'(fifo_level), 128'(4));
    chk("ovf flag", 128'(overflow), 128'(1));
`ifdef AES_OUT_DROP_CNT_EN
    chk("ovf drop_count", 128'(drop_count), 128'(1));
`endif
    repeat (18) step(1'b0, '0, 1'b1);

    // Back-to-back at core rate: one block every four cycles.
    max_level = 0;
    for (int b = 0; b < 8; b++) begin
      step(1'b1, rnd_blk(), 1'b1);
      repeat (3) step(1'b0, '0, 1'b1);
    end
    chk("b2b max level", 128'(max_level <= 2), 128'(1));
    repeat (3) step(1'b0, '0, 1'b1);

    // Reset while word 2 of the head block is presented, two more blocks queued.
    repeat (3) step(1'b1, rnd_blk(), 1'b0);
    repeat (2) step(1'b0, '0, 1'b1);
    in_valid = 1'b0;
    reset    = 1'b0;
    #1;
    chk("midrst out_valid", 128'(out_valid), 128'(0));
    chk("midrst out_data", 128'(out_data), 128'(0));
    chk("midrst out_last", 128'(out_last), 128'(0));
    chk("midrst fifo_level", 128'(fifo_level), 128'(0));
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    repeat (4) step(1'b0, '0, 1'b1);
    step(1'b1, rnd_blk(), 1'b1);
    repeat (5) step(1'b0, '0, 1'b1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 2) == 0, rnd_blk(), $urandom_range(0, 3) != 0);
    end
    for (int i = 0; i < 200; i++) begin
      step($urandom_range(0, 1) == 0, rnd_blk(), $urandom_range(0, 3) == 0);
    end
    repeat (20) step(1'b0, '0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
